// File: rtl/phy_tx_nlane.sv
// -----------------------------------------------------------------------------
// phy_tx_nlane
// Single-clock PHY transmit path. Each DATA_W-bit word is accepted through a
// valid/ready handshake and byte-striped across LANES serial lanes: lane l
// carries bytes l, l+LANES, l+2*LANES, ... Every lane is shifted out MSB-first,
// one bit per clk_32f cycle. All lanes stay in lockstep on a free-running
// 8-cycle symbol timer. When no word is pending, an idle symbol is sent.
//
// Optional feature macro:
//   PHY_TX_IDLE_COM_EN  defined -> idle symbol is K28.5 COM (raw 8'hBC)
//                       undefined -> idle symbol is 8'h00
//
// Ports:
//   clk_32f    in   bit clock, all state changes on its rising edge
//   reset      in   synchronous active-low reset
//   data_in    in   [DATA_W-1:0] word; byte 0 is the MSB byte
//   valid_in   in   data_in is valid
//   ready_out  out  word can be accepted (reset & ~buffer full)
//   data_out   out  [LANES-1:0] serial bit per lane
//   valid_out  out  registered; 1 while the shifting symbols carry word data
// -----------------------------------------------------------------------------
module phy_tx_nlane #(
    parameter int DATA_W = 32,
    parameter int LANES  = 2
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [LANES-1:0]  data_out,
    output logic              valid_out
);

    localparam int BYTES = DATA_W / 8;
    localparam int SPL   = BYTES / LANES;
    localparam int SYM_W = (SPL > 1) ? $clog2(SPL) : 1;

`ifdef PHY_TX_IDLE_COM_EN
    localparam logic [7:0] IDLE_SYM = 8'hBC;
`else
    localparam logic [7:0] IDLE_SYM = 8'h00;
`endif

    logic [2:0]        r_bit_cnt;
    logic [SYM_W-1:0]  r_sym_idx;
    logic              r_buf_full;
    logic [DATA_W-1:0] r_buf;
    logic [7:0]        r_sreg [LANES];
    logic              r_valid_out;

    logic w_accept;
    logic w_boundary;
    logic w_last_sym;

    assign ready_out  = reset & ~r_buf_full;
    assign w_accept   = valid_in & ready_out;
    assign w_boundary = (r_bit_cnt == 3'd7);
    assign w_last_sym = (r_sym_idx == SYM_W'(SPL - 1));
    assign valid_out  = r_valid_out;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            r_bit_cnt   <= 3'd0;
            r_sym_idx   <= '0;
            r_buf_full  <= 1'b0;
            r_valid_out <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                r_sreg[l] <= 8'h00;
            end
        end else begin
            r_bit_cnt <= r_bit_cnt + 3'd1;

            // Accept and drain are exclusive: accept needs the buffer empty,
            // drain needs it full.
            if (w_accept) begin
                r_buf_full <= 1'b1;
                r_sym_idx  <= '0;
            end else if (w_boundary && r_buf_full) begin
                if (w_last_sym) begin
                    r_buf_full <= 1'b0;
                end else begin
                    r_sym_idx <= r_sym_idx + 1'b1;
                end
            end

            if (w_boundary) begin
                r_valid_out <= r_buf_full;
            end

            // The buffer is shifted after each load, so the next symbol group
            // always sits in the top LANES bytes: lane l takes byte l of it.
            for (int l = 0; l < LANES; l++) begin
                if (w_boundary) begin
                    r_sreg[l] <= r_buf_full ? r_buf[DATA_W-1-8*l -: 8] : IDLE_SYM;
                end else begin
                    r_sreg[l] <= {r_sreg[l][6:0], 1'b0};
                end
            end
        end
    end

    // NOTE: the word buffer is data-only and has no reset; r_buf_full guards
    // every read of it, so its contents after reset are never observed.
    always_ff @(posedge clk_32f) begin
        if (w_accept) begin
            r_buf <= data_in;
        end else if (w_boundary && r_buf_full) begin
            r_buf <= r_buf << (8 * LANES);
        end
    end

    // NOTE: combinational outputs get a default before the loop so no path
    // leaves a bit unassigned and no latch is inferred.
    always_comb begin
        data_out = '0;
        for (int l = 0; l < LANES; l++) begin
            data_out[l] = r_sreg[l][7];
        end
    end

endmodule

// File: tb/tb_phy_tx_nlane.sv
// -----------------------------------------------------------------------------
// tb_phy_tx_nlane
// Drives a 2-lane and a 4-lane instance (DATA_W=32) from shared inputs and
// compares every cycle against a transaction-level model: accepted words become
// a queue of pending bytes, each symbol boundary turns LANES bytes (or the idle
// symbol) into per-lane bit queues, and one bit per lane leaves per cycle.
// Directed steps cover reset hold, a single word, back-to-back words, the
// 4-lane mapping and a mid-word reset; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_phy_tx_nlane;

`ifdef PHY_TX_IDLE_COM_EN
    localparam logic [7:0] IDLE_SYM = 8'hBC;
`else
    localparam logic [7:0] IDLE_SYM = 8'h00;
`endif

    logic        clk_32f = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready0, ready1;
    logic [1:0]  d0;
    logic [3:0]  d1;
    logic        v0, v1;

    always #5 clk_32f = ~clk_32f;

    phy_tx_nlane #(.DATA_W(32), .LANES(2)) u_dut2 (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready0), .data_out(d0), .valid_out(v0)
    );

    phy_tx_nlane #(.DATA_W(32), .LANES(4)) u_dut4 (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready1), .data_out(d1), .valid_out(v1)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model (index 0: 2 lanes, 1: 4 lanes) -------
    logic [7:0] pend   [2][$];
    bit         lane_q [2][4][$];
    int         m_cnt  [2];
    logic       m_valid[2];
    logic [3:0] m_out  [2];

    // ---------------- observation trackers (2-lane / 4-lane) ---------------
    int          cyc = 0;
    int          first_v = -1;
    int          cnt0 = 0, cnt1 = 0, run = 0, max_run = 0;
    logic [15:0] cap0, cap1;
    logic [7:0]  cap4 [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic exp_ready(input int i, input logic rst_n);
        return rst_n && (pend[i].size() == 0);
    endfunction

    task automatic model_init();
        for (int i = 0; i < 2; i++) begin
            pend[i].delete();
            for (int l = 0; l < 4; l++) lane_q[i][l].delete();
            m_cnt[i]   = 0;
            m_valid[i] = 1'b0;
            m_out[i]   = 4'h0;
        end
    endtask

    task automatic model_edge(input int i, input logic rst_n, input logic vin, input logic [31:0] din);
        int         n;
        logic       rdy;
        logic [7:0] b;
        n   = (i == 0) ? 2 : 4;
        rdy = exp_ready(i, rst_n);
        if (!rst_n) begin
            pend[i].delete();
            for (int l = 0; l < 4; l++) lane_q[i][l].delete();
            m_cnt[i]   = 0;
            m_valid[i] = 1'b0;
            m_out[i]   = 4'h0;
            return;
        end
        if (m_cnt[i] == 7) begin
            m_valid[i] = (pend[i].size() > 0);
            for (int l = 0; l < n; l++) begin
                b = m_valid[i] ? pend[i].pop_front() : IDLE_SYM;
                for (int j = 7; j >= 0; j--) lane_q[i][l].push_back(b[j]);
            end
        end
        if (vin && rdy) begin
            for (int k = 0; k < 4; k++) pend[i].push_back(din[31-8*k -: 8]);
        end
        for (int l = 0; l < n; l++) begin
            m_out[i][l] = (lane_q[i][l].size() > 0) ? lane_q[i][l].pop_front() : 1'b0;
        end
        m_cnt[i] = (m_cnt[i] + 1) % 8;
    endtask

    // One clock cycle: drive at negedge, check ready, edge, check outputs.
    task automatic step(input logic rst, input logic vin, input logic [31:0] din);
        reset    = rst;
        valid_in = vin;
        data_in  = din;
        #1;
        check("ready_l2", 32'(ready0), 32'(exp_ready(0, rst)));
        check("ready_l4", 32'(ready1), 32'(exp_ready(1, rst)));
        @(posedge clk_32f);
        model_edge(0, rst, vin, din);
        model_edge(1, rst, vin, din);
        @(negedge clk_32f);
        check("data_l2",  32'(d0), 32'(m_out[0][1:0]));
        check("data_l4",  32'(d1), 32'(m_out[1]));
        check("valid_l2", 32'(v0), 32'(m_valid[0]));
        check("valid_l4", 32'(v1), 32'(m_valid[1]));
        if (v0) begin
            cnt0++;
            run++;
            cap0 = {cap0[14:0], d0[0]};
            cap1 = {cap1[14:0], d0[1]};
            if (first_v < 0) first_v = cyc;
        end else begin
            run = 0;
        end
        if (run > max_run) max_run = run;
        if (v1) begin
            cnt1++;
            for (int l = 0; l < 4; l++) cap4[l] = {cap4[l][6:0], d1[l]};
        end
        cyc++;
    endtask

    task automatic clear_trackers();
        first_v = -1; cnt0 = 0; cnt1 = 0; run = 0; max_run = 0;
        cap0 = '0; cap1 = '0;
        for (int l = 0; l < 4; l++) cap4[l] = '0;
    endtask

    initial begin
        int          accept_cyc;
        int          accepted;
        logic [31:0] word;
        logic        r;

        reset = 1'b0; valid_in = 1'b0; data_in = '0;
        model_init();
        clear_trackers();
        @(negedge clk_32f);

        // Reset hold with valid_in high: nothing accepted, outputs at 0.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'hDEAD_BEEF);
        check("hold_no_valid", 32'(cnt0 + cnt1), 32'd0);

        // Single word accepted on the first edge after release (bit_cnt=0).
        clear_trackers();
        accept_cyc = cyc;
        step(1'b1, 1'b1, 32'hA5C3_0F81);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 32'h0);
        check("single_latency", 32'(first_v - accept_cyc), 32'd7);
        check("single_vcount",  32'(cnt0), 32'd16);
        check("single_lane0",   32'(cap0), 32'h0000_A50F);
        check("single_lane1",   32'(cap1), 32'h0000_C381);

        // Back-to-back words with valid_in held: 32 contiguous valid cycles.
        clear_trackers();
        accepted = 0;
        word = 32'h1122_3344;
        for (int i = 0; i < 60 && accepted < 2; i++) begin
            r = exp_ready(0, 1'b1);
            step(1'b1, 1'b1, word);
            if (r) begin
                accepted++;
                word = 32'h5566_7788;
            end
        end
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 32'h0);
        check("b2b_accepts", 32'(accepted), 32'd2);
        check("b2b_run",     32'(max_run), 32'd32);

        // 4-lane mapping: one symbol per lane, same 8-cycle window.
        clear_trackers();
        step(1'b1, 1'b1, 32'hF00F_AA55);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 32'h0);
        check("l4_vcount", 32'(cnt1), 32'd8);
        check("l4_lane0",  32'(cap4[0]), 32'h0000_00F0);
        check("l4_lane1",  32'(cap4[1]), 32'h0000_000F);
        check("l4_lane2",  32'(cap4[2]), 32'h0000_00AA);
        check("l4_lane3",  32'(cap4[3]), 32'h0000_0055);

        // Mid-word reset at the 5th data bit of the first symbol.
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h3C3C_A5A5);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);
        clear_trackers();
        step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 32'h0);
        check("midreset_dropped", 32'(cnt0), 32'd0);

        // Randomized traffic with rare resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), $urandom);
        end
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d observed=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
